// File: rtl/mdu_div.sv
// -----------------------------------------------------------------------------
// mdu_div - multicycle radix-2 restoring divider for DIV / DIVU.
//
// Takes the rs/rt register-file read data as dividend/divisor. It produces the
// quotient (written to LO) and the remainder (written to HI). The controller
// stalls the PC while busy is high and commits the result on the done pulse.
//
// Timing, with start sampled at edge E0:
//   E0            operands captured; busy rises
//   E1..E_WIDTH   one restoring step per edge
//   E_(WIDTH+1)   sign correction and result registration; busy falls
//   done is high for the single cycle after E_(WIDTH+1). A start sampled in
//   that cycle is accepted, so back-to-back throughput is WIDTH+2 cycles.
//
// Arithmetic follows MIPS rules:
//   - The quotient truncates toward zero.
//   - The remainder takes the dividend's sign.
//   - Dividing by zero gives quotient = all ones and remainder = the raw
//     dividend, with div_by_zero set.
//
// Ports:
//   clk          in   clock, all state changes on the rising edge
//   rst          in   asynchronous active-high reset
//   start        in   division request, only looked at while idle
//   is_signed    in   1 = DIV (two's complement), 0 = DIVU; captured at start
//   dividend     in   [WIDTH-1:0] rs value, captured at start
//   divisor      in   [WIDTH-1:0] rt value, captured at start
//   busy         out  operation in progress
//   done         out  one-cycle pulse, results valid from this cycle on
//   quotient     out  [WIDTH-1:0] to LO, held until the next done
//   remainder    out  [WIDTH-1:0] to HI, held until the next done
//   div_by_zero  out  divisor was zero, held until the next done
// -----------------------------------------------------------------------------
module mdu_div #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam logic [CNT_W-1:0] LP_LAST_STEP = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;

   // Iteration state
   logic [CNT_W-1:0]  r_cnt;
   logic [WIDTH:0]    r_rem;      // partial remainder
   logic [WIDTH-1:0]  r_quo;      // dividend in, quotient out (shift register)
   logic [WIDTH-1:0]  r_dvs;      // divisor magnitude
   logic              r_sign_q;
   logic              r_sign_r;
   logic              r_zero;

   // Registered outputs
   logic              r_done;
   logic [WIDTH-1:0]  r_quotient;
   logic [WIDTH-1:0]  r_remainder;
   logic              r_div_by_zero;

   // Control decodes
   logic              w_accept;
   logic              w_step;
   logic              w_fix;

   // Operand conditioning
   logic              w_dvd_neg;
   logic              w_dvs_neg;
   logic              w_dvs_zero;
   logic [WIDTH-1:0]  w_dvd_mag;
   logic [WIDTH-1:0]  w_dvs_mag;

   // One restoring step
   logic [WIDTH:0]    w_shift;
   logic [WIDTH+1:0]  w_diff;
   logic              w_neg;

   // The partial remainder always stays below the divisor magnitude, so its
   // top bit is never set and the shift only needs the low WIDTH bits.
   logic              w_unused_rem_msb;
   assign w_unused_rem_msb = r_rem[WIDTH];

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_RUN;
         S_RUN:   if (r_cnt == LP_LAST_STEP) w_state_next = S_FIX;
         S_FIX:   w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs and control decodes
   // -------------------------------------------------------------------------
   always_comb begin
      busy     = 1'b0;
      w_accept = 1'b0;
      w_step   = 1'b0;
      w_fix    = 1'b0;
      case (r_state)
         S_IDLE:  w_accept = start;
         S_RUN:   begin busy = 1'b1; w_step = 1'b1; end
         S_FIX:   begin busy = 1'b1; w_fix  = 1'b1; end
         default: ;
      endcase
   end

   // -------------------------------------------------------------------------
   // Operand conditioning
   // In unsigned mode neither operand is treated as negative. The magnitude
   // of the most negative value wraps onto itself. That is still the correct
   // value when read as unsigned, which is how the datapath uses it.
   // -------------------------------------------------------------------------
   assign w_dvd_neg  = is_signed & dividend[WIDTH-1];
   assign w_dvs_neg  = is_signed & divisor[WIDTH-1];
   assign w_dvs_zero = (divisor == '0);
   assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
   assign w_dvs_mag  = w_dvs_neg ? -divisor  : divisor;

   // -------------------------------------------------------------------------
   // Restoring step
   // Shift the remainder/quotient pair left and try subtracting the divisor.
   // The extra top bit of the difference is the borrow: when it is set the
   // trial went negative and the shifted value is restored.
   // -------------------------------------------------------------------------
   assign w_shift = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
   assign w_diff  = {1'b0, w_shift} - {2'b0, r_dvs};
   assign w_neg   = w_diff[WIDTH+1];

   // -------------------------------------------------------------------------
   // Datapath and result registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt         <= '0;
         r_rem         <= '0;
         r_quo         <= '0;
         r_dvs         <= '0;
         r_sign_q      <= 1'b0;
         r_sign_r      <= 1'b0;
         r_zero        <= 1'b0;
         r_done        <= 1'b0;
         r_quotient    <= '0;
         r_remainder   <= '0;
         r_div_by_zero <= 1'b0;
      end else begin
         r_done <= w_fix;

         if (w_accept) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            // With a zero divisor every trial subtract succeeds. The raw
            // dividend therefore shifts straight through into the remainder,
            // and the quotient fills with ones.
            r_quo    <= w_dvs_zero ? dividend : w_dvd_mag;
            r_dvs    <= w_dvs_mag;
            r_sign_q <= w_dvd_neg ^ w_dvs_neg;
            r_sign_r <= w_dvd_neg;
            r_zero   <= w_dvs_zero;
         end

         if (w_step) begin
            r_cnt <= r_cnt + 1'b1;
            r_rem <= w_neg ? w_shift : w_diff[WIDTH:0];
            r_quo <= {r_quo[WIDTH-2:0], ~w_neg};
         end

         if (w_fix) begin
            r_div_by_zero <= r_zero;
            if (r_zero) begin
               r_quotient  <= '1;
               r_remainder <= r_rem[WIDTH-1:0];
            end else begin
               r_quotient  <= r_sign_q ? -r_quo : r_quo;
               r_remainder <= r_sign_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
            end
         end
      end
   end

   assign done        = r_done;
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_mdu_div.sv
// -----------------------------------------------------------------------------
// tb_mdu_div - self-checking bench for mdu_div.
//
// A behavioural model tracks what the divider must show on every cycle. A
// single compare process checks the DUT against that model one time unit
// after each rising edge. Directed operations also pin results, latency and
// busy length to hand-computed constants. Randomized operations follow the
// directed ones.
// -----------------------------------------------------------------------------
module tb_mdu_div;

   localparam int W     = 32;
   localparam int CLK_P = 10;

   logic          clk;
   logic          rst;
   logic          start;
   logic          is_signed;
   logic [W-1:0]  dividend;
   logic [W-1:0]  divisor;
   logic          busy;
   logic          done;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
   logic          div_by_zero;

   int checks = 0;
   int errors = 0;

   mdu_div #(.WIDTH(W), .CNT_W(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #(CLK_P/2) clk = ~clk;

   // -------------------------------------------------------------------------
   // Comparison helper
   // -------------------------------------------------------------------------
   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // -------------------------------------------------------------------------
   // Reference arithmetic (MIPS DIV/DIVU) computed with plain integers.
   // Result packing: {div_by_zero, remainder, quotient}.
   // -------------------------------------------------------------------------
   function automatic logic [2*W:0] ref_div(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic s);
      logic [W-1:0] q;
      logic [W-1:0] r;
      longint sa, sb, ma, mb, q64, r64;
      if (b == 0) begin
         return {1'b1, a, {W{1'b1}}};
      end
      if (!s) begin
         q = a / b;
         r = a % b;
      end else begin
         sa  = longint'($signed(a));
         sb  = longint'($signed(b));
         ma  = (sa < 0) ? -sa : sa;
         mb  = (sb < 0) ? -sb : sb;
         q64 = ma / mb;
         r64 = ma % mb;
         if ((sa < 0) != (sb < 0)) q64 = -q64;
         if (sa < 0) r64 = -r64;
         q = q64[W-1:0];
         r = r64[W-1:0];
      end
      return {1'b0, r, q};
   endfunction

   // -------------------------------------------------------------------------
   // Cycle model.
   // m_cnt = -1 means idle; otherwise it counts edges since acceptance. The
   // result appears WIDTH+1 edges after the start edge.
   // -------------------------------------------------------------------------
   int           m_cnt  = -1;
   logic         m_done = 1'b0;
   logic [W-1:0] m_q    = '0;
   logic [W-1:0] m_r    = '0;
   logic         m_z    = 1'b0;
   logic [2*W:0] m_pend = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt  <= -1;
         m_done <= 1'b0;
         m_q    <= '0;
         m_r    <= '0;
         m_z    <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_cnt >= 0) begin
            if (m_cnt == W) begin
               m_cnt  <= -1;
               m_done <= 1'b1;
               m_q    <= m_pend[W-1:0];
               m_r    <= m_pend[2*W-1:W];
               m_z    <= m_pend[2*W];
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end else if (start) begin
            m_pend <= ref_div(dividend, divisor, is_signed);
            m_cnt  <= 0;
         end
      end
   end

   // Single compare process: every cycle, one time unit after the edge.
   always @(posedge clk) begin
      #1;
      chk("cyc_busy",     W'(busy),        W'(m_cnt >= 0));
      chk("cyc_done",     W'(done),        W'(m_done));
      chk("cyc_quotient", quotient,        m_q);
      chk("cyc_remainder",remainder,       m_r);
      chk("cyc_dbz",      W'(div_by_zero), W'(m_z));
   end

   // -------------------------------------------------------------------------
   // Run one division.
   // mode 0: normal.
   // mode 1: a new start with other operands is raised mid-operation.
   // mode 2: reset is asserted at cycle 15 and the task returns afterwards.
   // -------------------------------------------------------------------------
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input int mode, output int lat, output int busy_cnt,
                         output int n_done, output time t_done);
      lat = -1; busy_cnt = 0; n_done = 0; t_done = 0;
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b; is_signed = s;
      @(posedge clk);                       // E0
      @(negedge clk);
      // Scramble the inputs; the captured operands must be unaffected.
      start = 1'b0; dividend = $urandom; divisor = $urandom;
      is_signed = 1'($urandom_range(0, 1));
      if (busy) busy_cnt++;
      for (int k = 1; k <= 45; k++) begin
         @(posedge clk); #1;
         if (busy) busy_cnt++;
         if (done) begin
            n_done++;
            if (lat < 0) begin lat = k; t_done = $time; end
         end
         if (mode == 1 && k == 10) begin start = 1'b1; dividend = 99; divisor = 3; end
         if (mode == 1 && k == 11) start = 1'b0;
         if (mode == 2 && k == 15) begin
            @(negedge clk);
            rst = 1'b1;
            #1;
            chk("rst_busy",      W'(busy),        '0);
            chk("rst_done",      W'(done),        '0);
            chk("rst_quotient",  quotient,        '0);
            chk("rst_remainder", remainder,       '0);
            chk("rst_dbz",       W'(div_by_zero), '0);
            @(negedge clk);
            rst = 1'b0;
            $display("op %h / %h signed=%0d aborted by reset", a, b, s);
            return;
         end
         if (lat >= 0 && mode != 1) break;
      end
      if (lat < 0) begin
         errors++;
         $display("FAIL timeout: no done for %h / %h, got none, expected one within 45 cycles", a, b);
      end
      $display("op %h / %h signed=%0d -> q=%h r=%h dbz=%0d lat=%0d busy=%0d",
               a, b, s, quotient, remainder, div_by_zero, lat, busy_cnt);
   endtask

   function automatic logic [W-1:0] pick_val();
      case ($urandom_range(0, 6))
         0:       return '0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return W'($urandom_range(0, 20));
         4:       return -W'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   // -------------------------------------------------------------------------
   // Stimulus with hand-computed expectations
   // -------------------------------------------------------------------------
   initial begin
      int  lat, bcnt, nd;
      time t1, t2;
      rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy",      W'(busy),        '0);
      chk("reset_done",      W'(done),        '0);
      chk("reset_quotient",  quotient,        '0);
      chk("reset_remainder", remainder,       '0);
      chk("reset_dbz",       W'(div_by_zero), '0);
      @(negedge clk);
      rst = 1'b0;

      // Unsigned 100 / 7
      run_op(32'd100, 32'd7, 1'b0, 0, lat, bcnt, nd, t1);
      chk("u100_7_lat",  W'(lat),  W'(33));
      chk("u100_7_busy", W'(bcnt), W'(33));
      chk("u100_7_q",    quotient, 32'd14);
      chk("u100_7_r",    remainder, 32'd2);
      chk("u100_7_dbz",  W'(div_by_zero), '0);

      // Signed -7 / 2 and unsigned on the same bits
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, lat, bcnt, nd, t1);
      chk("s_m7_2_q", quotient,  32'hFFFF_FFFD);
      chk("s_m7_2_r", remainder, 32'hFFFF_FFFF);
      run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 0, lat, bcnt, nd, t1);
      chk("u_m7_2_q", quotient,  32'h7FFF_FFFC);
      chk("u_m7_2_r", remainder, 32'd1);

      // Signed overflow case
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, lat, bcnt, nd, t1);
      chk("ovf_q",   quotient,  32'h8000_0000);
      chk("ovf_r",   remainder, 32'd0);
      chk("ovf_dbz", W'(div_by_zero), '0);

      // Divide by zero, signed and unsigned
      for (int s = 1; s >= 0; s--) begin
         run_op(32'h1234_5678, 32'd0, 1'(s), 0, lat, bcnt, nd, t1);
         chk("dbz_lat", W'(lat),  W'(33));
         chk("dbz_q",   quotient,  32'hFFFF_FFFF);
         chk("dbz_r",   remainder, 32'h1234_5678);
         chk("dbz_flag",W'(div_by_zero), W'(1));
      end

      // Start while busy is ignored
      run_op(32'd50, 32'd5, 1'b0, 1, lat, bcnt, nd, t1);
      chk("busy_start_ndone", W'(nd), W'(1));
      chk("busy_start_q",     quotient,  32'd10);
      chk("busy_start_r",     remainder, 32'd0);

      // Reset mid-operation, then a clean 9 / 4
      run_op(32'd1000, 32'd7, 1'b0, 2, lat, bcnt, nd, t1);
      nd = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done) nd++;
      end
      chk("post_rst_no_done", W'(nd), '0);
      run_op(32'd9, 32'd4, 1'b0, 0, lat, bcnt, nd, t1);
      chk("r9_4_q", quotient,  32'd2);
      chk("r9_4_r", remainder, 32'd1);

      // Back-to-back: the next start is raised during the done cycle
      run_op(32'd17, 32'd5, 1'b0, 0, lat, bcnt, nd, t1);
      chk("b2b_first_q", quotient,  32'd3);
      chk("b2b_first_r", remainder, 32'd2);
      run_op(32'd1000, 32'd10, 1'b0, 0, lat, bcnt, nd, t2);
      chk("b2b_gap",      W'((t2 - t1) / CLK_P), W'(34));
      chk("b2b_second_q", quotient,  32'd100);

      // Randomized operations with random gaps (zero gap = back-to-back)
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] a, b;
         a = pick_val();
         b = pick_val();
         repeat ($urandom_range(0, 3)) @(posedge clk);
         run_op(a, b, 1'($urandom_range(0, 1)), 0, lat, bcnt, nd, t1);
         chk("rand_lat", W'(lat), W'(33));
      end

      repeat (5) @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global bound on run time
   initial begin
      #(CLK_P * 20000);
      errors++;
      $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
